// File: rtl/tof_pkg.sv
// Shared types and the 2-out-of-5 code table (weights 7-4-2-1-0, bits a..e).
package tof_pkg;

  localparam int CODE_W  = 5;
  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_e;

  typedef logic [CODE_W-1:0]  code_t;
  typedef logic [DIGIT_W-1:0] digit_t;

  // Codeword {a,b,c,d,e}; zero returned for anything that is not a BCD digit.
  function automatic code_t tof_encode(input digit_t d);
    code_t c;
    case (d)
      4'd0:    c = 5'b11000;
      4'd1:    c = 5'b00011;
      4'd2:    c = 5'b00101;
      4'd3:    c = 5'b00110;
      4'd4:    c = 5'b01001;
      4'd5:    c = 5'b01010;
      4'd6:    c = 5'b01100;
      4'd7:    c = 5'b10001;
      4'd8:    c = 5'b10010;
      4'd9:    c = 5'b10100;
      default: c = 5'b00000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tof_digit_encoder.sv
// Combinational BCD -> 2-of-5 lookup with an out-of-range flag.
module tof_digit_encoder
  import tof_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [CODE_W-1:0]  code,
  output logic               invalid
);

  assign code    = tof_encode(digit);
  assign invalid = (digit > 4'd9);

endmodule

// File: rtl/two_of_five_tx.sv
// 2-of-5 serial transmitter: accepts BCD digits on valid/ready, sends each
// codeword MSB (bit a) first, BIT_CYCLES clocks per bit, then GAP_CYCLES idle.
// Optional feature macro TOF_CHECK_DIGIT_EN: appends a mod-10 check digit
// frame after any digit accepted with in_last=1.
module two_of_five_tx
  import tof_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] in_digit,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic               tx_bit,
  output logic               tx_frame,
  output logic [CODE_W-1:0]  code,
  output logic               err
);

  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int BIT_W = $clog2(CODE_W);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CODE_W - 1);

  state_e             state_q, state_d;
  code_t              code_q, code_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               err_q, err_d;

  digit_t             enc_in;
  code_t              enc_code;
  logic               enc_invalid;
  code_t              cur_code;
  state_e             after_data;
  logic               accept, sending, in_gap, frame_end, gap_end;

  assign accept    = (state_q == IDLE) && in_valid;
  assign frame_end = (cyc_q == CYC_LAST) && (bit_q == BIT_LAST);
  assign gap_end   = (gap_q == GAP_LAST);

`ifdef TOF_CHECK_DIGIT_EN
  digit_t           sum_q, sum_d;
  logic             pend_q, pend_d;
  logic             ck_gap_q, ck_gap_d;
  digit_t           chk_digit;
  logic [DIGIT_W:0] sum_ext;

  assign chk_digit  = (sum_q == 4'd0) ? 4'd0 : 4'd10 - sum_q;
  assign sum_ext    = {1'b0, sum_q} + {1'b0, in_digit};
  assign sending    = (state_q == SHIFT) || ((state_q == CHECK) && !ck_gap_q);
  assign in_gap     = (state_q == GAP) || ((state_q == CHECK) && ck_gap_q);
  assign after_data = pend_q ? CHECK : IDLE;
  // The check digit shares the single encoder; in CHECK its code comes straight from it.
  assign enc_in     = (state_q == CHECK) ? chk_digit : in_digit;
  assign cur_code   = (state_q == CHECK) ? enc_code : code_q;
`else
  logic unused_in_last;

  assign unused_in_last = in_last;
  assign sending    = (state_q == SHIFT);
  assign in_gap     = (state_q == GAP);
  assign after_data = IDLE;
  assign enc_in     = in_digit;
  assign cur_code   = code_q;
`endif

  tof_digit_encoder u_enc (
    .digit   (enc_in),
    .code    (enc_code),
    .invalid (enc_invalid)
  );

  // State, counters and holding registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      code_q  <= code_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!enc_invalid) state_d = SHIFT;
`ifdef TOF_CHECK_DIGIT_EN
          else if (in_last) state_d = CHECK;
`endif
        end
      end
      SHIFT: if (frame_end) state_d = (GAP_CYCLES > 0) ? GAP : after_data;
      GAP:   if (gap_end) state_d = after_data;
`ifdef TOF_CHECK_DIGIT_EN
      CHECK: if (ck_gap_q ? gap_end : (frame_end && (GAP_CYCLES == 0))) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Bit/cycle/gap counters, codeword capture and the error pulse.
  always_comb begin
    code_d = code_q;
    bit_d  = '0;
    cyc_d  = '0;
    gap_d  = '0;
    err_d  = accept && enc_invalid;
    if (accept && !enc_invalid) code_d = enc_code;
    if (sending) begin
      if (cyc_q == CYC_LAST) begin
        bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
      end else begin
        bit_d = bit_q;
        cyc_d = cyc_q + 1'b1;
      end
    end
    if (in_gap && !gap_end) gap_d = gap_q + 1'b1;
  end

`ifdef TOF_CHECK_DIGIT_EN
  // Message checksum, pending-check flag and CHECK sub-phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q    <= '0;
      pend_q   <= 1'b0;
      ck_gap_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      pend_q   <= pend_d;
      ck_gap_q <= ck_gap_d;
    end
  end

  // Accumulate valid digits mod 10; clear everything once the check frame is done.
  always_comb begin
    sum_d    = sum_q;
    pend_d   = pend_q;
    ck_gap_d = ck_gap_q;
    if (accept) begin
      if (!enc_invalid) sum_d = (sum_ext >= 5'd10) ? DIGIT_W'(sum_ext - 5'd10) : sum_ext[DIGIT_W-1:0];
      // An invalid closing digit jumps straight to CHECK, so nothing is left pending.
      pend_d = in_last && !enc_invalid;
    end
    if (state_q == CHECK) begin
      pend_d = 1'b0;
      if (!ck_gap_q && frame_end && (GAP_CYCLES > 0)) ck_gap_d = 1'b1;
      if (state_d == IDLE) begin
        ck_gap_d = 1'b0;
        sum_d    = '0;
      end
    end
  end
`endif

  // Outputs: serial line and code are forced to 0 outside a frame.
  always_comb begin
    in_ready = (state_q == IDLE);
    tx_frame = sending;
    code     = sending ? cur_code : '0;
    tx_bit   = sending ? cur_code[BIT_LAST - bit_q] : 1'b0;
    err      = err_q;
  end

endmodule

// File: tb/tb_two_of_five_tx.sv
// Directed bench for two_of_five_tx: dut_a runs BIT_CYCLES=1/GAP=0,
// dut_b runs BIT_CYCLES=4/GAP=2. Received frames are decoded by an
// independent 2-of-5 checker (weights 7-4-2-1-0).
module tb_two_of_five_tx;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic [3:0] digit_a = '0, digit_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       last_a = 1'b0, last_b = 1'b0;
  logic       ready_a, ready_b, txb_a, txb_b, frame_a, frame_b, err_a, err_b;
  logic [4:0] code_a, code_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  two_of_five_tx #(.BIT_CYCLES(1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst_a), .in_digit(digit_a), .in_valid(valid_a), .in_last(last_a),
    .in_ready(ready_a), .tx_bit(txb_a), .tx_frame(frame_a), .code(code_a), .err(err_a)
  );

  two_of_five_tx #(.BIT_CYCLES(4), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst_b), .in_digit(digit_b), .in_valid(valid_b), .in_last(last_b),
    .in_ready(ready_b), .tx_bit(txb_b), .tx_frame(frame_b), .code(code_b), .err(err_b)
  );

  typedef struct {
    logic [3:0] digit;
    logic [4:0] code;
    logic       err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int d); return d != 0 ? ready_b : ready_a; endfunction
  function automatic logic frm(input int d); return d != 0 ? frame_b : frame_a; endfunction
  function automatic logic txb(input int d); return d != 0 ? txb_b : txb_a; endfunction
  function automatic logic er(input int d);  return d != 0 ? err_b : err_a; endfunction
  function automatic logic [4:0] cd(input int d); return d != 0 ? code_b : code_a; endfunction

  // Far-end checker model: weighted sum, with 7+4 standing for zero.
  function automatic int tof_decode(input logic [4:0] w);
    int s;
    s = 7 * w[4] + 4 * w[3] + 2 * w[2] + w[1];
    return (s == 11) ? 0 : s;
  endfunction

  task automatic set_in(input int d, input logic v, input logic [3:0] dig, input logic l);
    if (d != 0) begin valid_b = v; digit_b = dig; last_b = l; end
    else        begin valid_a = v; digit_a = dig; last_a = l; end
  endtask

  // Present one digit; returns at the falling edge of the first cycle after the transfer.
  task automatic send(input int d, input logic [3:0] dig, input logic l);
    int n = 0;
    while (!rdy(d) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready wait", {31'd0, rdy(d)}, 32'd1);
    set_in(d, 1'b1, dig, l);
    @(posedge clk);
    @(negedge clk);
    set_in(d, 1'b0, 4'd0, 1'b0);
  endtask

  // Sample one frame of 5*bc cycles starting at the current falling edge.
  task automatic capture(input int d, input int bc, output logic [4:0] word,
                         output int flen, output int unstable, output logic [4:0] code_seen);
    word = '0; flen = 0; unstable = 0; code_seen = cd(d);
    for (int i = 0; i < 5 * bc; i++) begin
      if (frm(d)) flen++;
      if (i % bc == 0) word[4 - i / bc] = txb(d);
      else if (txb(d) !== word[4 - i / bc]) unstable++;
      if (cd(d) !== code_seen) unstable++;
      @(negedge clk);
    end
  endtask

  task automatic expect_frame(input string tag, input int d, input int bc,
                              input logic [4:0] exp, input int exp_digit);
    logic [4:0] w, c;
    int fl, un;
    capture(d, bc, w, fl, un, c);
    check({tag, " bits"}, {27'd0, w}, {27'd0, exp});
    check({tag, " code"}, {27'd0, c}, {27'd0, exp});
    check({tag, " frame len"}, fl, 5 * bc);
    check({tag, " stable"}, un, 0);
    check({tag, " popcount"}, $countones(w), 2);
    check({tag, " decode"}, tof_decode(w), exp_digit);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'd0,  5'b11000, 1'b0};
    vecs[1]  = '{4'd1,  5'b00011, 1'b0};
    vecs[2]  = '{4'd2,  5'b00101, 1'b0};
    vecs[3]  = '{4'd3,  5'b00110, 1'b0};
    vecs[4]  = '{4'd4,  5'b01001, 1'b0};
    vecs[5]  = '{4'd5,  5'b01010, 1'b0};
    vecs[6]  = '{4'd6,  5'b01100, 1'b0};
    vecs[7]  = '{4'd7,  5'b10001, 1'b0};
    vecs[8]  = '{4'd8,  5'b10010, 1'b0};
    vecs[9]  = '{4'd9,  5'b10100, 1'b0};
    vecs[10] = '{4'd10, 5'b00000, 1'b1};
    vecs[11] = '{4'd15, 5'b00000, 1'b1};

    // Reset state.
    #2;
    check("rst ready", {31'd0, ready_a}, 32'd1);
    check("rst frame", {31'd0, frame_a}, 32'd0);
    check("rst tx_bit", {31'd0, txb_a}, 32'd0);
    check("rst code", {27'd0, code_a}, 32'd0);
    check("rst err", {31'd0, err_a}, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    // Table: every digit plus two invalid ones, random idle gaps, BIT_CYCLES=1 GAP=0.
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(0, vecs[k].digit, 1'b0);
      if (vecs[k].err) begin
        check($sformatf("d%0d err pulse", vecs[k].digit), {31'd0, err_a}, 32'd1);
        check($sformatf("d%0d no frame", vecs[k].digit), {31'd0, frame_a}, 32'd0);
        check($sformatf("d%0d ready", vecs[k].digit), {31'd0, ready_a}, 32'd1);
        @(negedge clk);
        check($sformatf("d%0d err drop", vecs[k].digit), {31'd0, err_a}, 32'd0);
        check($sformatf("d%0d still idle", vecs[k].digit), {31'd0, frame_a}, 32'd0);
      end else begin
        check($sformatf("d%0d err", vecs[k].digit), {31'd0, err_a}, 32'd0);
        check($sformatf("d%0d busy", vecs[k].digit), {31'd0, ready_a}, 32'd0);
        expect_frame($sformatf("d%0d", vecs[k].digit), 0, 1, vecs[k].code, int'(vecs[k].digit));
        check($sformatf("d%0d frame end", vecs[k].digit), {31'd0, frame_a}, 32'd0);
        check($sformatf("d%0d ready after", vecs[k].digit), {31'd0, ready_a}, 32'd1);
      end
    end

    // BIT_CYCLES=4 GAP=2: digit 7 then 3 offered back-to-back.
    send(1, 4'd7, 1'b0);
    expect_frame("b7", 1, 4, 5'b10001, 7);
    check("b gap1 frame", {31'd0, frame_b}, 32'd0);
    check("b gap1 tx", {31'd0, txb_b}, 32'd0);
    check("b gap1 ready", {31'd0, ready_b}, 32'd0);
    set_in(1, 1'b1, 4'd3, 1'b0);
    @(negedge clk);
    check("b gap2 ready", {31'd0, ready_b}, 32'd0);
    check("b gap2 frame", {31'd0, frame_b}, 32'd0);
    @(negedge clk);
    check("b idle ready", {31'd0, ready_b}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    set_in(1, 1'b0, 4'd0, 1'b0);
    expect_frame("b3", 1, 4, 5'b00110, 3);

    // Async reset in the third bit of digit 9, then a clean restart with digit 5.
    repeat (3) @(negedge clk);
    send(1, 4'd9, 1'b0);
    repeat (8) @(negedge clk);
    check("pre-rst bit c", {31'd0, txb_b}, 32'd1);
    check("pre-rst frame", {31'd0, frame_b}, 32'd1);
    #1 rst_b = 1'b1;
    #1;
    check("mid rst tx_bit", {31'd0, txb_b}, 32'd0);
    check("mid rst frame", {31'd0, frame_b}, 32'd0);
    check("mid rst code", {27'd0, code_b}, 32'd0);
    check("mid rst err", {31'd0, err_b}, 32'd0);
    check("mid rst ready", {31'd0, ready_b}, 32'd1);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    check("post rst frame", {31'd0, frame_b}, 32'd0);
    check("post rst ready", {31'd0, ready_b}, 32'd1);
    send(1, 4'd5, 1'b0);
    expect_frame("b5", 1, 4, 5'b01010, 5);

`ifdef TOF_CHECK_DIGIT_EN
    // Check digit: clear the sum left over from the table run first.
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    send(0, 4'd1, 1'b0);
    expect_frame("m1 d1", 0, 1, 5'b00011, 1);
    send(0, 4'd2, 1'b0);
    expect_frame("m1 d2", 0, 1, 5'b00101, 2);
    send(0, 4'd3, 1'b1);
    expect_frame("m1 d3", 0, 1, 5'b00110, 3);
    check("m1 check busy", {31'd0, ready_a}, 32'd0);
    expect_frame("m1 check", 0, 1, 5'b01001, 4);
    check("m1 done ready", {31'd0, ready_a}, 32'd1);
    check("m1 done frame", {31'd0, frame_a}, 32'd0);
    send(0, 4'd5, 1'b1);
    expect_frame("m2 d5", 0, 1, 5'b01010, 5);
    expect_frame("m2 check", 0, 1, 5'b01010, 5);
    send(0, 4'd12, 1'b1);
    check("m3 err", {31'd0, err_a}, 32'd1);
    expect_frame("m3 check", 0, 1, 5'b11000, 0);
    check("m3 done ready", {31'd0, ready_a}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
